// File: rtl/segre_pkg.sv
// rtl/segre_pkg.sv - shared types for the Segre hazard scheduler
package segre_pkg;

    localparam int SEGRE_REG_SIZE = 5;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_EX   = 2'd1,
        FWD_MEM  = 2'd2,
        FWD_WB   = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic                      valid;
        logic                      we;
        logic [SEGRE_REG_SIZE-1:0] waddr;
        logic                      prod_mem;
    } sb_entry_t;

    // x0 is hardwired, so it never names a real producer
    function automatic logic entry_writes(input sb_entry_t e,
                                          input logic [SEGRE_REG_SIZE-1:0] r);
        return e.valid && e.we && (e.waddr == r) && (r != '0);
    endfunction

endpackage

// File: rtl/segre_fwd_match.sv
// rtl/segre_fwd_match.sv - per-operand writer match, bypass select and load-use flag
module segre_fwd_match
    import segre_pkg::*;
(
    input  logic                      i_live,
    input  logic [SEGRE_REG_SIZE-1:0] i_raddr,
    input  sb_entry_t                 i_ex,
    input  sb_entry_t                 i_mem,
    input  sb_entry_t                 i_wb,
    output fwd_sel_e                  o_sel,
    output logic                      o_load_use
);

    logic w_unused;

    // a load sitting in MEM or WB already has its data by the time this operand reaches EX
    assign w_unused = i_mem.prod_mem ^ i_wb.prod_mem;

    always_comb begin
        o_sel      = FWD_NONE;
        o_load_use = 1'b0;
        if (i_live) begin
            if (entry_writes(i_ex, i_raddr)) begin
                o_sel      = FWD_EX;
                o_load_use = i_ex.prod_mem;
            end else if (entry_writes(i_mem, i_raddr)) begin
                o_sel = FWD_MEM;
            end else if (entry_writes(i_wb, i_raddr)) begin
                o_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/segre_hazard_ctrl.sv
// rtl/segre_hazard_ctrl.sv - ID issue/stall/flush scheduler; SEGRE_BYPASS_EN enables operand bypass
module segre_hazard_ctrl
    import segre_pkg::*;
#(
    parameter int REG_SIZE = SEGRE_REG_SIZE,
    parameter int CNT_W    = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                id_valid_i,
    input  logic [REG_SIZE-1:0] raddr_a_i,
    input  logic [REG_SIZE-1:0] raddr_b_i,
    input  logic                rd_raddr_a_i,
    input  logic                rd_raddr_b_i,
    input  logic [REG_SIZE-1:0] waddr_i,
    input  logic                rf_we_i,
    input  logic                prod_ex_i,
    input  logic                prod_mem_i,
    input  logic                flush_i,
    input  logic                mem_stall_i,
    output logic                stall_id_o,
    output fwd_sel_e            fwd_a_o,
    output fwd_sel_e            fwd_b_o,
    output logic [CNT_W-1:0]    stall_cnt_o
);

    sb_entry_t        r_ex, r_mem, r_wb;
    logic [CNT_W-1:0] r_stall_cnt;

    sb_entry_t w_new;
    fwd_sel_e  w_sel_a, w_sel_b;
    logic      w_lu_a, w_lu_b, w_hazard;
    logic      w_unused_prod_ex;

    assign w_unused_prod_ex = prod_ex_i;

    assign w_new = '{valid:    id_valid_i,
                     we:       rf_we_i,
                     waddr:    SEGRE_REG_SIZE'(waddr_i),
                     prod_mem: prod_mem_i};

    segre_fwd_match u_match_a (
        .i_live     (id_valid_i & rd_raddr_a_i),
        .i_raddr    (SEGRE_REG_SIZE'(raddr_a_i)),
        .i_ex       (r_ex),
        .i_mem      (r_mem),
        .i_wb       (r_wb),
        .o_sel      (w_sel_a),
        .o_load_use (w_lu_a)
    );

    segre_fwd_match u_match_b (
        .i_live     (id_valid_i & rd_raddr_b_i),
        .i_raddr    (SEGRE_REG_SIZE'(raddr_b_i)),
        .i_ex       (r_ex),
        .i_mem      (r_mem),
        .i_wb       (r_wb),
        .o_sel      (w_sel_b),
        .o_load_use (w_lu_b)
    );

`ifdef SEGRE_BYPASS_EN
    assign w_hazard = w_lu_a | w_lu_b;
    assign fwd_a_o  = w_sel_a;
    assign fwd_b_o  = w_sel_b;
`else
    // without bypass the reader must wait until the writer has left WB
    assign w_hazard = (w_sel_a != FWD_NONE) | (w_sel_b != FWD_NONE) | w_lu_a | w_lu_b;
    assign fwd_a_o  = FWD_NONE;
    assign fwd_b_o  = FWD_NONE;
`endif

    assign stall_id_o  = mem_stall_i | (~flush_i & w_hazard);
    assign stall_cnt_o = r_stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_stall_cnt <= '0;
        end else if (!mem_stall_i) begin
            r_mem <= r_ex;
            r_wb  <= r_mem;
            if (flush_i || w_hazard) begin
                r_ex <= '0;
            end else begin
                r_ex <= w_new;
            end
            if (!flush_i && w_hazard) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    a_prod_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
        !(prod_ex_i && prod_mem_i));

endmodule

// File: tb/tb_segre_hazard_ctrl.sv
// tb/tb_segre_hazard_ctrl.sv - scoreboard bench for segre_hazard_ctrl
module tb_segre_hazard_ctrl;
    import segre_pkg::*;

    localparam int CNT_W = 32;
`ifdef SEGRE_BYPASS_EN
    localparam int RAW_COST = 0;
    localparam int LU_COST  = 1;
`else
    localparam int RAW_COST = 3;
    localparam int LU_COST  = 3;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid_i;
    logic [4:0]       raddr_a_i, raddr_b_i, waddr_i;
    logic             rd_raddr_a_i, rd_raddr_b_i;
    logic             rf_we_i, prod_ex_i, prod_mem_i, flush_i, mem_stall_i;
    logic             stall_id_o;
    fwd_sel_e         fwd_a_o, fwd_b_o;
    logic [CNT_W-1:0] stall_cnt_o;

    segre_hazard_ctrl #(.REG_SIZE(5), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .id_valid_i   (id_valid_i),
        .raddr_a_i    (raddr_a_i),
        .raddr_b_i    (raddr_b_i),
        .rd_raddr_a_i (rd_raddr_a_i),
        .rd_raddr_b_i (rd_raddr_b_i),
        .waddr_i      (waddr_i),
        .rf_we_i      (rf_we_i),
        .prod_ex_i    (prod_ex_i),
        .prod_mem_i   (prod_mem_i),
        .flush_i      (flush_i),
        .mem_stall_i  (mem_stall_i),
        .stall_id_o   (stall_id_o),
        .fwd_a_o      (fwd_a_o),
        .fwd_b_o      (fwd_b_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {bit v; bit we; int wa; bit pm;} ent_t;
    typedef struct {string name; bit stall; int fa; int fb; longint cnt;} exp_t;

    ent_t   pipe[3];
    longint m_cnt;
    exp_t   sbq[$];
    int     checks = 0;
    int     failures = 0;
    bit     pred_stall;

    function automatic void check(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic bit writes(ent_t e, int r);
        return e.v && e.we && e.wa == r && r != 0;
    endfunction

    // youngest in-flight writer wins; 0 = none, 1/2/3 = EX/MEM/WB
    function automatic int src_sel(bit live, int r);
        if (!live) return 0;
        for (int i = 0; i < 3; i++)
            if (writes(pipe[i], r)) return i + 1;
        return 0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
        m_cnt = 0;
    endfunction

    task automatic step(string nm, bit idv, int ra, bit rda, int rb, bit rdb,
                        int wa, bit we, bit pm, bit fl, bit ms);
        exp_t e;
        int   sa, sb;
        bit   haz;
        @(posedge clk);
        #1;
        id_valid_i   = idv;
        raddr_a_i    = 5'(ra);
        rd_raddr_a_i = rda;
        raddr_b_i    = 5'(rb);
        rd_raddr_b_i = rdb;
        waddr_i      = 5'(wa);
        rf_we_i      = we;
        prod_mem_i   = we & pm;
        prod_ex_i    = we & ~pm;
        flush_i      = fl;
        mem_stall_i  = ms;
        sa = src_sel(idv && rda, ra);
        sb = src_sel(idv && rdb, rb);
`ifdef SEGRE_BYPASS_EN
        haz  = ((sa == 1) || (sb == 1)) && pipe[0].pm;
        e.fa = sa;
        e.fb = sb;
`else
        haz  = (sa != 0) || (sb != 0);
        e.fa = 0;
        e.fb = 0;
`endif
        e.name  = nm;
        e.stall = ms || (!fl && haz);
        e.cnt   = m_cnt;
        sbq.push_back(e);
        pred_stall = e.stall;
        if (!ms) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (fl || haz) pipe[0] = '{0, 0, 0, 0};
            else           pipe[0] = '{idv, we, wa, we & pm};
            if (!fl && haz) m_cnt = (m_cnt + 1) & 64'hFFFF_FFFF;
        end
    endtask

    task automatic idle();
        step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue(string nm, int ra, bit rda, int rb, bit rdb, int wa, bit we, bit pm);
        int n = 0;
        do begin
            step(nm, 1, ra, rda, rb, rdb, wa, we, pm, 0, 0);
            n++;
        end while (pred_stall && n < 8);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && sbq.size() > 0) begin
            e = sbq.pop_front();
            check({e.name, "_stall"}, longint'(stall_id_o), longint'(e.stall));
            check({e.name, "_fwd_a"}, longint'(fwd_a_o), longint'(e.fa));
            check({e.name, "_fwd_b"}, longint'(fwd_b_o), longint'(e.fb));
            check({e.name, "_cnt"}, longint'(stall_cnt_o), e.cnt);
        end
    end

    initial begin
        longint base;
        int     guard;
        rst = 1'b1;
        id_valid_i = 0; raddr_a_i = 0; raddr_b_i = 0; rd_raddr_a_i = 0; rd_raddr_b_i = 0;
        waddr_i = 0; rf_we_i = 0; prod_ex_i = 0; prod_mem_i = 0; flush_i = 0; mem_stall_i = 0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_stall", longint'(stall_id_o), 0);
        check("reset_fwd_a", longint'(fwd_a_o), 0);
        check("reset_fwd_b", longint'(fwd_b_o), 0);
        check("reset_cnt", longint'(stall_cnt_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ALU result consumed immediately
        issue("addi_x5", 0, 1, 0, 0, 5, 1, 0);
        issue("add_x6", 5, 1, 5, 1, 6, 1, 0);
        repeat (3) idle();
        check("raw_cost", longint'(stall_cnt_o), RAW_COST);

        // load followed by dependent
        base = m_cnt;
        issue("lw_x7", 1, 1, 0, 0, 7, 1, 1);
        issue("addi_x8", 7, 1, 0, 0, 8, 1, 0);
        repeat (3) idle();
        check("load_use_cost", longint'(stall_cnt_o), base + LU_COST);

        // x0 never hazards
        issue("wr_x0", 1, 1, 0, 0, 0, 1, 1);
        issue("rd_x0", 0, 1, 0, 1, 9, 1, 0);
        repeat (3) idle();

        // writer distance 1, 2, 3, then two writers in flight
        issue("wr_x3_d1", 0, 0, 0, 0, 3, 1, 0);
        issue("rd_x3_d1", 3, 1, 0, 0, 10, 1, 0);
        repeat (3) idle();
        issue("wr_x3_d2", 0, 0, 0, 0, 3, 1, 0);
        issue("nop", 0, 0, 0, 0, 0, 0, 0);
        issue("rd_x3_d2", 0, 0, 3, 1, 10, 1, 0);
        repeat (3) idle();
        issue("wr_x3_d3", 0, 0, 0, 0, 3, 1, 0);
        issue("nop", 0, 0, 0, 0, 0, 0, 0);
        issue("nop", 0, 0, 0, 0, 0, 0, 0);
        issue("rd_x3_d3", 3, 1, 0, 0, 10, 1, 0);
        repeat (3) idle();
        issue("wr_x3_old", 0, 0, 0, 0, 3, 1, 0);
        issue("wr_x3_new", 0, 0, 0, 0, 3, 1, 0);
        issue("rd_x3_two", 3, 1, 3, 1, 11, 1, 0);
        repeat (3) idle();

        // flush beats load-use, then a memory freeze
        issue("lw_x9", 1, 1, 0, 0, 9, 1, 1);
        step("flush_lu", 1, 9, 1, 0, 0, 12, 1, 0, 1, 0);
        repeat (4) step("mem_stall", 1, 9, 1, 0, 0, 12, 1, 0, 0, 1);
        issue("after_freeze", 9, 1, 0, 0, 12, 1, 0);
        repeat (3) idle();

        issue("add_x5", 1, 1, 2, 1, 5, 1, 0);
        issue("sub_x6", 5, 1, 2, 1, 6, 1, 0);
        repeat (3) idle();

        for (int i = 0; i < 400; i++) begin
            bit we = $urandom_range(0, 1);
            step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                 $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), we,
                 we & ($urandom_range(0, 2) == 0), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 11) == 0);
        end
        repeat (3) idle();

        // asynchronous reset while a stall is showing
        issue("lw_x5", 1, 1, 0, 0, 5, 1, 1);
        step("pre_rst_hazard", 1, 5, 1, 0, 0, 13, 1, 0, 0, 0);
        @(negedge clk);
        #1;
        check("pre_rst_cnt_nonzero", longint'(stall_cnt_o != 0), 1);
        rst = 1'b1;
        #1;
        check("async_rst_stall", longint'(stall_id_o), 0);
        check("async_rst_cnt", longint'(stall_cnt_o), 0);
        check("async_rst_fwd_a", longint'(fwd_a_o), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        issue("post_rst_rd", 5, 1, 0, 0, 6, 1, 0);
        repeat (2) idle();

        guard = 0;
        while (sbq.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        check("scoreboard_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
